layer_output_serializer: RTL and testbench

- Sits between two neuron layers. Collects the per-neuron outputs of one layer and streams them, one word per cycle, into the shared input bus of the next layer.
- Each neuron raises its own output valid, in any order and in any cycle. Words are captured per neuron, buffered once a full frame is complete, then emitted in ascending neuron order under a ready handshake.
- Double-buffered: the next frame is collected while the current frame streams.

---
 rtl/layer_output_serializer.sv | 134 +++++++++++++
 tb/tb_layer_output_serializer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_output_serializer.sv
// Collects one output word per neuron, then streams the completed frame in ascending neuron order
// under an all-bits-ready handshake. Define LAYER_SERIALIZER_ARGMAX_EN to add per-frame argmax outputs.
module layer_output_serializer #(
  parameter int NUM_NEURON      = 10,
  parameter int DATA_WIDTH      = 16,
  parameter int NEXT_NUM_NEURON = 10,
  localparam int IDX_W          = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_NEURON-1:0]            i_data_valid,
  input  logic [NEXT_NUM_NEURON-1:0]       i_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_data_valid,
  output logic                             o_busy,
  output logic                             o_frame_done,
  output logic                             o_overflow
`ifdef LAYER_SERIALIZER_ARGMAX_EN
  ,
  output logic [IDX_W-1:0]                 o_max_index,
  output logic                             o_max_valid
`endif
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [NUM_NEURON-1:0]   flag_p0;
  logic [DATA_WIDTH-1:0]   hold_p0  [NUM_NEURON];
  logic [DATA_WIDTH-1:0]   frame_p1 [NUM_NEURON];
  logic [IDX_W-1:0]        idx_p1;
  logic [IDX_W-1:0]        next_idx;
  logic                    load;
  logic                    xfer;
  logic                    last;

  assign next_idx     = idx_p1 + 1'b1;
  assign o_busy       = (state_q == STREAM);
  assign o_data_valid = (state_q == STREAM);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    xfer    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (&flag_p0) begin
          state_d = STREAM;
          load    = 1'b1;
        end
      end
      STREAM: begin
        if (&i_ready) begin
          xfer = 1'b1;
          if (idx_p1 == IDX_W'(NUM_NEURON - 1)) begin
            last    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: per-neuron capture; a pulse on the load edge re-arms its flag for the next frame
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      flag_p0    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (|(i_data_valid & flag_p0)) o_overflow <= 1'b1;
      flag_p0 <= (load ? '0 : flag_p0) | i_data_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_NEURON; k++) begin
      if (i_data_valid[k]) hold_p0[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    if (load) frame_p1 <= hold_p0;
  end

  // Stage p1: frame buffer streamed out through a registered output word
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      idx_p1       <= '0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      o_frame_done <= last;
      if (load) begin
        idx_p1 <= '0;
        o_data <= hold_p0[0];
      end else if (xfer && !last) begin
        idx_p1 <= next_idx;
        o_data <= frame_p1[next_idx];
      end
    end
  end

`ifdef LAYER_SERIALIZER_ARGMAX_EN
  logic signed [DATA_WIDTH-1:0] word_s;
  logic signed [DATA_WIDTH-1:0] run_max_p1;
  logic [IDX_W-1:0]             run_idx_p1;
  logic                         take;

  // Strict greater-than keeps the lowest index on ties
  assign word_s = o_data;
  assign take   = (idx_p1 == '0) || (word_s > run_max_p1);

  always_ff @(posedge i_clk) begin
    if (xfer && take) begin
      run_max_p1 <= word_s;
      run_idx_p1 <= idx_p1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_max_index <= '0;
      o_max_valid <= 1'b0;
    end else begin
      o_max_valid <= last;
      if (last) o_max_index <= take ? idx_p1 : run_idx_p1;
    end
  end
`endif

endmodule

// File: tb/tb_layer_output_serializer.sv
// Randomized plus directed bench for layer_output_serializer against a queue-based frame model.
module tb_layer_output_serializer;

  localparam int N = 10;
  localparam int W = 16;
  localparam int R = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] data;
  logic [N-1:0]   dv;
  logic [R-1:0]   rdy;
  logic [W-1:0]   o_data;
  logic           o_data_valid;
  logic           o_busy;
  logic           o_frame_done;
  logic           o_overflow;
`ifdef LAYER_SERIALIZER_ARGMAX_EN
  logic [3:0]     o_max_index;
  logic           o_max_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;

  layer_output_serializer #(.NUM_NEURON(N), .DATA_WIDTH(W), .NEXT_NUM_NEURON(R)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_data       (data),
    .i_data_valid (dv),
    .i_ready      (rdy),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_overflow   (o_overflow)
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    ,
    .o_max_index  (o_max_index),
    .o_max_valid  (o_max_valid)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: pending words per neuron, and the frame being sent as a queue
  bit           m_flag [N];
  logic [W-1:0] m_hold [N];
  logic [W-1:0] m_q [$];
  bit           m_stream;
  bit           m_done;
  bit           m_ovf;
  int           m_best;
  int           m_max_idx;
  bit           m_max_valid;

  function automatic void model_reset();
    for (int k = 0; k < N; k++) m_flag[k] = 1'b0;
    m_q.delete();
    m_stream    = 1'b0;
    m_done      = 1'b0;
    m_ovf       = 1'b0;
    m_max_idx   = 0;
    m_max_valid = 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      bit old_flag [N];
      bit all;
      bit fin;
      all = 1'b1;
      fin = 1'b0;
      for (int k = 0; k < N; k++) begin
        old_flag[k] = m_flag[k];
        all = all & m_flag[k];
      end
      if (m_stream) begin
        if (&rdy) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_stream = 1'b0;
            fin      = 1'b1;
          end
        end
      end else if (all) begin
        m_best = 0;
        for (int k = 0; k < N; k++) begin
          m_q.push_back(m_hold[k]);
          if ($signed(m_hold[k]) > $signed(m_hold[m_best])) m_best = k;
          m_flag[k] = 1'b0;
        end
        m_stream = 1'b1;
      end
      m_done      = fin;
      m_max_valid = fin;
      if (fin) m_max_idx = m_best;
      for (int k = 0; k < N; k++) begin
        if (dv[k]) begin
          if (old_flag[k]) m_ovf = 1'b1;
          m_hold[k] = data[k*W +: W];
          m_flag[k] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (rst) model_reset();
    chk("valid", 32'(o_data_valid), 32'(m_stream));
    chk("busy", 32'(o_busy), 32'(m_stream));
    chk("frame_done", 32'(o_frame_done), 32'(m_done));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    if (m_stream) chk("data", 32'(o_data), 32'(m_q[0]));
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    chk("max_valid", 32'(o_max_valid), 32'(m_max_valid));
    chk("max_index", 32'(o_max_index), 32'(m_max_idx));
`endif
  end

  task automatic step();
    @(negedge clk);
    #1;
    dv = '0;
  endtask

  task automatic wait_idx(input int t);
    int n;
    n = 0;
    while (!(m_stream && (N - m_q.size()) == t)) begin
      step();
      n++;
      if (n > 60) begin
        chk("wait_idx_timeout", 32'(n), 32'(0));
        return;
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!o_frame_done) begin
      step();
      n++;
      if (n > 80) begin
        chk("wait_done_timeout", 32'(n), 32'(0));
        return;
      end
    end
  endtask

  task automatic load_all(input logic [W-1:0] w [N]);
    for (int k = 0; k < N; k++) data[k*W +: W] = w[k];
    dv = '1;
  endtask

  logic [W-1:0] fa [N];
  logic [W-1:0] fb [N];

  initial begin
    model_reset();
    rst  = 1'b1;
    data = '0;
    dv   = '0;
    rdy  = '1;
    step();
    step();
    chk("rst_valid", 32'(o_data_valid), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_done", 32'(o_frame_done), 32'h0);
    chk("rst_ovf", 32'(o_overflow), 32'h0);
    chk("rst_data", 32'(o_data), 32'h0);
    rst = 1'b0;
    step();

    // All neurons in one cycle, words 0x10*k+1
    for (int k = 0; k < N; k++) fa[k] = W'(16 * k + 1);
    load_all(fa);
    step();
    chk("t1_not_yet", 32'(o_data_valid), 32'h0);
    step();
    chk("t1_first", 32'(o_data), 32'h0001);
    for (int k = 0; k < N; k++) begin
      chk("t1_valid", 32'(o_data_valid), 32'h1);
      chk("t1_word", 32'(o_data), 32'(16 * k + 1));
      if (k == N - 1) chk("t1_last", 32'(o_data), 32'h0091);
      step();
    end
    chk("t1_done", 32'(o_frame_done), 32'h1);
    chk("t1_idle", 32'(o_data_valid), 32'h0);
    step();
    chk("t1_done_pulse", 32'(o_frame_done), 32'h0);

    // Reverse arrival order
    for (int k = N - 1; k >= 0; k--) begin
      step();
      fa[k] = W'($urandom);
      data[k*W +: W] = fa[k];
      dv[k] = 1'b1;
      chk("t2_hold_off", 32'(o_data_valid), 32'h0);
    end
    step();
    chk("t2_hold_off2", 32'(o_data_valid), 32'h0);
    step();
    chk("t2_start", 32'(o_data_valid), 32'h1);
    chk("t2_word0", 32'(o_data), 32'(fa[0]));
    wait_done();

    // Stall with one ready bit low on the word at idx 2
    for (int k = 0; k < N; k++) fa[k] = W'($urandom);
    step();
    load_all(fa);
    wait_idx(2);
    rdy[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_stall_word", 32'(o_data), 32'(fa[2]));
      chk("t3_stall_valid", 32'(o_data_valid), 32'h1);
    end
    rdy = '1;
    step();
    chk("t3_resume", 32'(o_data), 32'(fa[3]));
    wait_done();
    step();

    // Next frame collected during the current stream
    for (int k = 0; k < N; k++) begin
      fa[k] = W'($urandom);
      fb[k] = W'($urandom);
    end
    load_all(fa);
    wait_idx(3);
    load_all(fb);
    wait_done();
    chk("t4_gap", 32'(o_data_valid), 32'h0);
    step();
    chk("t4_restream", 32'(o_data_valid), 32'h1);
    chk("t4_word0", 32'(o_data), 32'(fb[0]));
    chk("t4_no_ovf", 32'(o_overflow), 32'h0);
    wait_done();
    step();

    // Neuron 4 re-validated before its frame loads
    data[4*W +: W] = 16'h1234;
    dv[4] = 1'b1;
    step();
    data[4*W +: W] = 16'h5678;
    dv[4] = 1'b1;
    step();
    chk("t5_ovf", 32'(o_overflow), 32'h1);
    for (int k = 0; k < N; k++) if (k != 4) data[k*W +: W] = W'($urandom);
    dv = ~(N'(1) << 4);
    wait_idx(4);
    chk("t5_second_word", 32'(o_data), 32'h5678);
    wait_done();
    step();

`ifdef LAYER_SERIALIZER_ARGMAX_EN
    fa = '{16'hFFFD, 16'h0007, 16'h0007, 16'h8000, 16'h0002,
           16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    load_all(fa);
    wait_done();
    chk("am_valid", 32'(o_max_valid), 32'h1);
    chk("am_index", 32'(o_max_index), 32'h1);
    step();
`endif

    // Reset in the middle of a frame
    for (int k = 0; k < N; k++) fa[k] = W'($urandom);
    load_all(fa);
    wait_idx(5);
    rst = 1'b1;
    #1;
    chk("t6_valid", 32'(o_data_valid), 32'h0);
    chk("t6_busy", 32'(o_busy), 32'h0);
    chk("t6_done", 32'(o_frame_done), 32'h0);
    chk("t6_ovf", 32'(o_overflow), 32'h0);
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < N; k++) fa[k] = W'($urandom);
    load_all(fa);
    wait_idx(0);
    chk("t6_fresh_word0", 32'(o_data), 32'(fa[0]));
    wait_done();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
      data = {$urandom, $urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < N; k++) dv[k] = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 3) == 0) ? R'($urandom) : '1;
    end
    step();
    rst = 1'b0;
    rdy = '1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
